// File: rtl/codec_spi_tx_pkg.sv
// Shared types and defaults for the codec control-port SPI transmitter.
// Holds the FSM state encoding, default timing constants and counter sizing helpers.
package codec_spi_tx_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_SHIFT = 3'd2,
      S_HOLD  = 3'd3,
      S_GAP   = 3'd4
   } state_e;

   localparam int DEF_DATA_W   = 16;
   localparam int DEF_CLK_DIV  = 4;
   localparam int DEF_CS_SETUP = 2;
   localparam int DEF_CS_HOLD  = 2;
   localparam int DEF_GAP      = 2;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   // Width of a down-counter that must hold values up to max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   // Width of the bit index counter; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/codec_spi_tx_phase_timer.sv
// Loadable down-counter with a terminal-count flag; times setup, SCK half-periods,
// hold and gap intervals for the SPI transmitter.
module codec_spi_tx_phase_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Loading N-1 makes tc fire on the Nth cycle after the load.
   assign tc = (cnt_q == '0);

endmodule

// File: rtl/codec_spi_tx.sv
// Write-only mode-0 SPI master: sends one DATA_W-bit word MSB first per accepted trg,
// framed by cs_n with programmable setup, hold and gap, then pulses done as rdy returns.
module codec_spi_tx
   import codec_spi_tx_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int CS_SETUP = DEF_CS_SETUP,
   parameter int CS_HOLD  = DEF_CS_HOLD,
   parameter int GAP      = DEF_GAP
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data,
   input  logic              trg,
   output logic              rdy,
   output logic              mosi,
   output logic              sck,
   output logic              cs_n,
   output logic              done
);

   localparam int TW    = cnt_width(max4(CLK_DIV, CS_SETUP, CS_HOLD, GAP));
   localparam int BIT_W = idx_width(DATA_W);

   localparam logic [TW-1:0]    SETUP_LD = TW'(CS_SETUP - 1);
   localparam logic [TW-1:0]    DIV_LD   = TW'(CLK_DIV - 1);
   localparam logic [TW-1:0]    HOLD_LD  = TW'(CS_HOLD - 1);
   localparam logic [TW-1:0]    GAP_LD   = TW'(GAP - 1);
   localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(DATA_W - 1);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic                rdy_q, rdy_d;
   logic                cs_n_q, cs_n_d;
   logic                sck_q, sck_d;
   logic                mosi_q, mosi_d;
   logic                done_q, done_d;

   logic                tmr_load;
   logic [TW-1:0]       tmr_val;
   logic                tmr_tc;

   codec_spi_tx_phase_timer #(
      .W (TW)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tc       (tmr_tc)
   );

   always_comb begin
      // NOTE: every signal gets its hold value first so no path through the case leaves one unassigned (no latch).
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      rdy_d     = rdy_q;
      cs_n_d    = cs_n_q;
      sck_d     = sck_q;
      mosi_d    = mosi_q;
      done_d    = 1'b0;
      tmr_load  = 1'b0;
      tmr_val   = '0;

      unique case (state_q)
         S_IDLE: begin
            if (trg) begin
               shift_d  = data;
               mosi_d   = data[DATA_W-1];
               cs_n_d   = 1'b0;
               rdy_d    = 1'b0;
               state_d  = S_SETUP;
               tmr_load = 1'b1;
               tmr_val  = SETUP_LD;
            end
         end

         S_SETUP: begin
            if (tmr_tc) begin
               state_d   = S_SHIFT;
               bit_cnt_d = LAST_IDX;
               tmr_load  = 1'b1;
               tmr_val   = DIV_LD;
            end
         end

         S_SHIFT: begin
            if (tmr_tc) begin
               tmr_load = 1'b1;
               tmr_val  = DIV_LD;
               if (!sck_q) begin
                  sck_d = 1'b1;
               end else begin
                  // mosi moves on the same edge that drops sck, so it never changes while sck is high.
                  sck_d = 1'b0;
                  if (bit_cnt_q != '0) begin
                     shift_d   = {shift_q[DATA_W-2:0], shift_q[DATA_W-1]};
                     mosi_d    = shift_q[DATA_W-2];
                     bit_cnt_d = bit_cnt_q - 1'b1;
                  end else begin
                     state_d = S_HOLD;
                     tmr_val = HOLD_LD;
                  end
               end
            end
         end

         S_HOLD: begin
            if (tmr_tc) begin
               cs_n_d   = 1'b1;
               state_d  = S_GAP;
               tmr_load = 1'b1;
               tmr_val  = GAP_LD;
            end
         end

         S_GAP: begin
            if (tmr_tc) begin
               rdy_d   = 1'b1;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         rdy_q     <= 1'b1;
         cs_n_q    <= 1'b1;
         sck_q     <= 1'b0;
         mosi_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         rdy_q     <= rdy_d;
         cs_n_q    <= cs_n_d;
         sck_q     <= sck_d;
         mosi_q    <= mosi_d;
         done_q    <= done_d;
      end
   end

   assign rdy  = rdy_q;
   assign cs_n = cs_n_q;
   assign sck  = sck_q;
   assign mosi = mosi_q;
   assign done = done_q;

endmodule

// File: tb/tb_codec_spi_tx.sv
// Self-checking bench for codec_spi_tx: default 16-bit instance plus an 8-bit, CLK_DIV=1 instance,
// with bus monitors that rebuild each frame and compare it against a queue of expected words.
module tb_codec_spi_tx;

   localparam int LAT16 = 2 + 2 * 4 * 16 + 2 + 2;
   localparam int LAT8  = 2 + 2 * 1 * 8 + 2 + 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] data;
   logic        trg;
   logic        rdy, mosi, sck, cs_n, done;
   logic [7:0]  data8;
   logic        trg8;
   logic        rdy8, mosi8, sck8, cs8, done8;

   int n_tests = 0;
   int n_fail  = 0;
   int frames  = 0;
   int frames8 = 0;
   int dones   = 0;

   logic [15:0] exp_q[$];
   logic [7:0]  exp8_q[$];

   typedef struct {
      logic [15:0] data;
      int          lat;
   } vec16_t;

   typedef struct {
      logic [7:0] data;
      int         lat;
   } vec8_t;

   vec16_t v16[11];
   vec8_t  v8[4];

   always #5 clk = ~clk;

   codec_spi_tx dut (
      .clk   (clk),
      .reset (reset),
      .data  (data),
      .trg   (trg),
      .rdy   (rdy),
      .mosi  (mosi),
      .sck   (sck),
      .cs_n  (cs_n),
      .done  (done)
   );

   codec_spi_tx #(
      .DATA_W  (8),
      .CLK_DIV (1)
   ) dut8 (
      .clk   (clk),
      .reset (reset),
      .data  (data8),
      .trg   (trg8),
      .rdy   (rdy8),
      .mosi  (mosi8),
      .sck   (sck8),
      .cs_n  (cs8),
      .done  (done8)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor for the 16-bit instance ----------------
   logic        prev_sck  = 1'b0;
   logic        prev_mosi = 1'b0;
   logic        prev_cs   = 1'b1;
   logic        prev_done = 1'b0;
   logic        seen_end  = 1'b0;
   logic [15:0] rx        = '0;
   int          nbits     = 0;
   int          cs_hi     = 0;

   always @(negedge clk) begin
      if (reset) begin
         prev_sck = 1'b0; prev_mosi = 1'b0; prev_cs = 1'b1; prev_done = 1'b0;
         seen_end = 1'b0; rx = '0; nbits = 0; cs_hi = 0;
      end else begin
         if (prev_sck && sck) check("mosi_stable_while_sck_high", mosi, prev_mosi);
         if (cs_n) check("sck_low_while_cs_high", sck, 0);
         if (!prev_sck && sck) begin
            check("sck_rise_inside_frame", cs_n, 0);
            rx = {rx[14:0], mosi};
            nbits++;
         end
         if (prev_cs && !cs_n) begin
            if (seen_end) check("cs_high_at_least_gap", cs_hi >= 2, 1);
            nbits = 0;
         end
         cs_hi = cs_n ? cs_hi + 1 : 0;
         if (!prev_cs && cs_n) begin
            frames++;
            seen_end = 1'b1;
            check("frame_sck_rises", nbits, 16);
            if (exp_q.size() == 0) check("frame_expected", 0, 1);
            else check("frame_word", rx, exp_q.pop_front());
         end
         if (done) begin
            dones++;
            check("done_single_cycle", prev_done, 0);
         end
         prev_sck = sck; prev_mosi = mosi; prev_cs = cs_n; prev_done = done;
      end
   end

   // ---------------- monitor for the 8-bit instance ----------------
   logic       p8_sck  = 1'b0;
   logic       p8_mosi = 1'b0;
   logic       p8_cs   = 1'b1;
   logic [7:0] rx8     = '0;
   int         n8      = 0;
   int         since8  = 0;

   always @(negedge clk) begin
      if (reset) begin
         p8_sck = 1'b0; p8_mosi = 1'b0; p8_cs = 1'b1; rx8 = '0; n8 = 0; since8 = 0;
      end else begin
         since8++;
         if (p8_sck && sck8) check("mosi8_stable_while_sck_high", mosi8, p8_mosi);
         if (cs8) check("sck8_low_while_cs_high", sck8, 0);
         if (p8_cs && !cs8) n8 = 0;
         if (!p8_sck && sck8) begin
            if (n8 > 0) check("sck8_period", since8, 2);
            since8 = 0;
            rx8 = {rx8[6:0], mosi8};
            n8++;
         end
         if (!p8_cs && cs8) begin
            frames8++;
            check("frame8_sck_rises", n8, 8);
            if (exp8_q.size() == 0) check("frame8_expected", 0, 1);
            else check("frame8_word", rx8, exp8_q.pop_front());
         end
         p8_sck = sck8; p8_mosi = mosi8; p8_cs = cs8;
      end
   end

   // ---------------- driver tasks (called at #1 after a rising edge) ----------------
   task automatic wait_rdy(input int limit, output int cyc);
      cyc = 0;
      while (rdy !== 1'b1 && cyc < limit) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic start_word(input logic [15:0] d);
      int c;
      wait_rdy(400, c);
      check("rdy_before_trg", rdy, 1);
      data = d;
      trg  = 1'b1;
      @(posedge clk);
      exp_q.push_back(d);
      #1;
      trg = 1'b0;
      check("rdy_falls_on_accept", rdy, 0);
      check("cs_low_on_accept", cs_n, 0);
   endtask

   task automatic finish_word(input int exp_lat);
      int c;
      wait_rdy(400, c);
      check("accept_to_rdy_latency", c, exp_lat);
      check("done_with_rdy", done, 1);
   endtask

   task automatic start8(input logic [7:0] d);
      int c = 0;
      while (rdy8 !== 1'b1 && c < 100) begin
         @(posedge clk); #1;
         c++;
      end
      check("rdy8_before_trg", rdy8, 1);
      data8 = d;
      trg8  = 1'b1;
      @(posedge clk);
      exp8_q.push_back(d);
      #1;
      trg8 = 1'b0;
      check("rdy8_falls_on_accept", rdy8, 0);
   endtask

   task automatic finish8(input int exp_lat);
      int c = 0;
      while (rdy8 !== 1'b1 && c < 100) begin
         @(posedge clk); #1;
         c++;
      end
      check("accept_to_rdy8_latency", c, exp_lat);
      check("done8_with_rdy", done8, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int f_before;
      int d_before;

      v16[0]  = '{16'h1E00, LAT16};
      v16[1]  = '{16'h0C10, LAT16};
      v16[2]  = '{16'h0E02, LAT16};
      v16[3]  = '{16'h1000, LAT16};
      v16[4]  = '{16'h0017, LAT16};
      v16[5]  = '{16'h0217, LAT16};
      v16[6]  = '{16'h0479, LAT16};
      v16[7]  = '{16'h0679, LAT16};
      v16[8]  = '{16'h08D2, LAT16};
      v16[9]  = '{16'h0A06, LAT16};
      v16[10] = '{16'h1201, LAT16};
      v8[0]   = '{8'h81, LAT8};
      v8[1]   = '{8'h00, LAT8};
      v8[2]   = '{8'hFF, LAT8};
      v8[3]   = '{8'h5A, LAT8};

      reset = 1'b1;
      trg   = 1'b0;
      trg8  = 1'b0;
      data  = '0;
      data8 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rdy", rdy, 1);
      check("reset_cs_n", cs_n, 1);
      check("reset_sck", sck, 0);
      check("reset_mosi", mosi, 0);
      check("reset_done", done, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;

      // single frame, latency and done pulse
      start_word(16'h1E00);
      finish_word(LAT16);
      @(posedge clk); #1;
      check("done_drops_after_one_cycle", done, 0);
      check("frames_after_single", frames, 1);

      // eleven back-to-back frames, trg raised the cycle rdy returns
      foreach (v16[i]) begin
         start_word(v16[i].data);
         finish_word(v16[i].lat);
      end
      repeat (4) @(posedge clk); #1;
      check("frames_after_burst", frames, 12);

      // trg mid-frame with different data is ignored
      start_word(16'h3C5A);
      repeat (40) @(posedge clk);
      #1;
      data = 16'hFFFF;
      trg  = 1'b1;
      @(posedge clk); #1;
      trg = 1'b0;
      check("rdy_still_low_mid_frame", rdy, 0);
      finish_word(LAT16 - 41);
      repeat (20) @(posedge clk); #1;
      check("no_extra_frame", frames, 13);
      check("idle_cs_after_ignored_trg", cs_n, 1);
      check("expected_queue_drained", exp_q.size(), 0);

      // async reset in the middle of bit 7 of 16'hA5A5
      start_word(16'hA5A5);
      repeat (70) @(posedge clk);
      #2;
      check("mid_bit7_cs_low", cs_n, 0);
      check("mid_bit7_sck_high", sck, 1);
      check("mid_bit7_mosi", mosi, 1);
      check("mid_bit7_rises_so_far", nbits, 8);
      f_before = frames;
      d_before = dones;
      reset = 1'b1;
      #1;
      check("abort_cs_n", cs_n, 1);
      check("abort_sck", sck, 0);
      check("abort_mosi", mosi, 0);
      check("abort_rdy", rdy, 1);
      check("abort_done", done, 0);
      void'(exp_q.pop_back());
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (150) @(posedge clk); #1;
      check("abort_no_frame_end", frames, f_before);
      check("abort_no_done", dones, d_before);
      check("abort_idle_rdy", rdy, 1);

      // recovery frame after the abort
      start_word(16'h0C0C);
      finish_word(LAT16);

      // 8-bit, CLK_DIV=1 instance
      foreach (v8[i]) begin
         start8(v8[i].data);
         finish8(v8[i].lat);
      end
      repeat (4) @(posedge clk); #1;
      check("frames8_total", frames8, 4);
      check("expected8_queue_drained", exp8_q.size(), 0);
      check("expected_queue_final", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
